fp32_add_timed: RTL and testbench

- IEEE-754 single-precision adder with a fixed 5-cycle pipeline and a built-in latency timer.
- The timer raises a completion flag once the sum of the launched operands is available on the output.
- Used by the CORDIC final-adder stage.
- The stage controller launches one operation with start, holds operands stable and watches done before sampling result.

---
 rtl/fp32_pkg.sv | 36 +++
 rtl/latency_timer.sv | 39 +++
 rtl/fp32_add_timed.sv | 219 +++++++++++++++++++++
 tb/tb_fp32_add_timed.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the CORDIC arithmetic stages: field layout,
// special encodings, default adder latency and a leading-zero counter.
package fp32_pkg;

  localparam int SIGN_W         = 1;
  localparam int EXP_W          = 8;
  localparam int MAN_W          = 23;
  localparam int EXP_BIAS       = 127;
  localparam int FP_ADD_LATENCY = 5;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Leading zeros of a 27-bit significand-plus-GRS word; 27 when the word is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/latency_timer.sv
// Launch-to-completion timer: start loads the counter to 1, it counts up to
// LATENCY and then raises a sticky done flag until the next start.
module latency_timer
  import fp32_pkg::*;
#(
  parameter int LATENCY     = FP_ADD_LATENCY,
  parameter int COUNT_WIDTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam logic [COUNT_WIDTH-1:0] TERMINAL  = COUNT_WIDTH'(LATENCY);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   done_reg;

  // A zero count means idle: no start has been seen since reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else if (start) begin
      count_reg <= COUNT_ONE;
      done_reg  <= 1'b0;
    end else if ((count_reg != '0) && (count_reg < TERMINAL)) begin
      count_reg <= count_reg + COUNT_ONE;
      if ((count_reg + COUNT_ONE) == TERMINAL) begin
        done_reg <= 1'b1;
      end
    end
  end

  assign done = done_reg;

endmodule

// File: rtl/fp32_add_timed.sv
// Five-stage FP32 adder (RNE, flush-to-zero) with a launch-to-done timer used
// by the CORDIC final-adder stage.
module fp32_add_timed
  import fp32_pkg::*;
#(
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int ADD_LATENCY      = FP_ADD_LATENCY,
  parameter int COUNT_WIDTH      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        start,
  input  logic [FLOAT_DATA_WIDTH-1:0] dataa,
  input  logic [FLOAT_DATA_WIDTH-1:0] datab,
  output logic [FLOAT_DATA_WIDTH-1:0] result,
  output logic                        done
);

  // ---------------- stage 1: unpack, classify, order by magnitude
  fp32_t       op_a, op_b;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [7:0]  exp_a_f, exp_b_f;
  logic [23:0] sig_a, sig_b;
  logic        special_next;
  logic [31:0] special_val_next;

  assign op_a    = dataa;
  assign op_b    = datab;
  assign a_nan   = (op_a.exp == 8'hFF) && (op_a.man != '0);
  assign b_nan   = (op_b.exp == 8'hFF) && (op_b.man != '0);
  assign a_inf   = (op_a.exp == 8'hFF) && (op_a.man == '0);
  assign b_inf   = (op_b.exp == 8'hFF) && (op_b.man == '0);
  assign a_zero  = (op_a.exp == 8'h00);
  assign b_zero  = (op_b.exp == 8'h00);
  assign exp_a_f = a_zero ? 8'h00 : op_a.exp;
  assign exp_b_f = b_zero ? 8'h00 : op_b.exp;
  assign sig_a   = a_zero ? 24'h0 : {1'b1, op_a.man};
  assign sig_b   = b_zero ? 24'h0 : {1'b1, op_b.man};
  assign swap    = {exp_b_f, sig_b} > {exp_a_f, sig_a};

  always_comb begin
    special_next     = 1'b0;
    special_val_next = FP32_QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (op_a.sign != op_b.sign))) begin
      special_next = 1'b1;
    end else if (a_inf) begin
      special_next     = 1'b1;
      special_val_next = op_a.sign ? FP32_NEG_INF : FP32_POS_INF;
    end else if (b_inf) begin
      special_next     = 1'b1;
      special_val_next = op_b.sign ? FP32_NEG_INF : FP32_POS_INF;
    end
  end

  logic        s1_sign_l, s1_sign_s, s1_special, s1_zero_sign;
  logic [7:0]  s1_exp_l, s1_exp_s;
  logic [23:0] s1_sig_l, s1_sig_s;
  logic [31:0] s1_special_val;

  // ---------------- stage 2: align the smaller operand, folding lost bits into sticky
  logic [7:0]  align_diff;
  logic [26:0] align_ext, align_shifted, lost_mask, aligned_next;

  assign align_diff    = s1_exp_l - s1_exp_s;
  assign align_ext     = {s1_sig_s, 3'b000};
  assign align_shifted = align_ext >> align_diff;

  genvar gi;
  generate
    for (gi = 0; gi < 27; gi++) begin : g_lost_mask
      assign lost_mask[gi] = (8'(gi) < align_diff);
    end
  endgenerate

  always_comb begin
    if (align_diff >= 8'd26) begin
      aligned_next = {26'h0, |s1_sig_s};
    end else begin
      aligned_next = {align_shifted[26:1], align_shifted[0] | (|(align_ext & lost_mask))};
    end
  end

  logic        s2_sign, s2_sub, s2_special, s2_zero_sign;
  logic [7:0]  s2_exp;
  logic [26:0] s2_sig_l, s2_sig_s;
  logic [31:0] s2_special_val;

  // ---------------- stage 3: add or subtract (|large| >= |small| so no negative result)
  logic [27:0] sum_next;
  assign sum_next = s2_sub ? ({1'b0, s2_sig_l} - {1'b0, s2_sig_s})
                           : ({1'b0, s2_sig_l} + {1'b0, s2_sig_s});

  logic        s3_sign, s3_special, s3_zero_sign;
  logic [7:0]  s3_exp;
  logic [27:0] s3_sum;
  logic [31:0] s3_special_val;

  // ---------------- stage 4: normalise, detect exact zero and denormal underflow
  logic [4:0]        norm_lz;
  logic [26:0]       norm_next;
  logic signed [9:0] exp_norm_next;
  logic              zero_next, zero_sign_next;

  assign norm_lz = lzc27(s3_sum[26:0]);

  always_comb begin
    if (s3_sum[27]) begin
      norm_next     = {s3_sum[27:2], s3_sum[1] | s3_sum[0]};
      exp_norm_next = 10'(s3_exp) + 10'sd1;
    end else begin
      norm_next     = s3_sum[26:0] << norm_lz;
      exp_norm_next = 10'(s3_exp) - 10'(norm_lz);
    end
    zero_next      = 1'b0;
    zero_sign_next = 1'b0;
    if (s3_sum == '0) begin
      zero_next      = 1'b1;
      zero_sign_next = s3_zero_sign;
    end else if (exp_norm_next <= 10'sd0) begin
      zero_next = 1'b1;
    end
  end

  logic              s4_sign, s4_special, s4_zero, s4_zero_sign;
  logic signed [9:0] s4_exp;
  logic [26:0]       s4_norm;
  logic [31:0]       s4_special_val;

  // ---------------- stage 5: round to nearest even, renormalise, pack
  logic              round_up;
  logic [24:0]       rounded;
  logic signed [9:0] exp_round;
  logic [22:0]       man_round;
  logic [31:0]       result_next;

  assign round_up  = s4_norm[2] & (s4_norm[1] | s4_norm[0] | s4_norm[3]);
  assign rounded   = {1'b0, s4_norm[26:3]} + {24'h0, round_up};
  assign exp_round = s4_exp + (rounded[24] ? 10'sd1 : 10'sd0);
  assign man_round = rounded[24] ? rounded[23:1] : rounded[22:0];

  always_comb begin
    if (s4_special) begin
      result_next = s4_special_val;
    end else if (s4_zero) begin
      result_next = {s4_zero_sign, 31'h0};
    end else if (exp_round >= 10'sd255) begin
      result_next = s4_sign ? FP32_NEG_INF : FP32_POS_INF;
    end else begin
      result_next = {s4_sign, exp_round[7:0], man_round};
    end
  end

  logic [31:0] result_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_sign_l <= 1'b0;  s1_sign_s <= 1'b0;  s1_special <= 1'b0;  s1_zero_sign <= 1'b0;
      s1_exp_l  <= '0;    s1_exp_s  <= '0;    s1_sig_l   <= '0;    s1_sig_s     <= '0;
      s1_special_val <= '0;
      s2_sign <= 1'b0;  s2_sub <= 1'b0;  s2_special <= 1'b0;  s2_zero_sign <= 1'b0;
      s2_exp  <= '0;    s2_sig_l <= '0;  s2_sig_s   <= '0;    s2_special_val <= '0;
      s3_sign <= 1'b0;  s3_special <= 1'b0;  s3_zero_sign <= 1'b0;
      s3_exp  <= '0;    s3_sum     <= '0;    s3_special_val <= '0;
      s4_sign <= 1'b0;  s4_special <= 1'b0;  s4_zero <= 1'b0;  s4_zero_sign <= 1'b0;
      s4_exp  <= '0;    s4_norm    <= '0;    s4_special_val <= '0;
      result_reg <= '0;
    end else if (clk_en) begin
      s1_sign_l      <= swap ? op_b.sign : op_a.sign;
      s1_sign_s      <= swap ? op_a.sign : op_b.sign;
      s1_exp_l       <= swap ? exp_b_f : exp_a_f;
      s1_exp_s       <= swap ? exp_a_f : exp_b_f;
      s1_sig_l       <= swap ? sig_b : sig_a;
      s1_sig_s       <= swap ? sig_a : sig_b;
      s1_special     <= special_next;
      s1_special_val <= special_val_next;
      s1_zero_sign   <= op_a.sign & op_b.sign;

      s2_sign        <= s1_sign_l;
      s2_sub         <= s1_sign_l ^ s1_sign_s;
      s2_exp         <= s1_exp_l;
      s2_sig_l       <= {s1_sig_l, 3'b000};
      s2_sig_s       <= aligned_next;
      s2_special     <= s1_special;
      s2_special_val <= s1_special_val;
      s2_zero_sign   <= s1_zero_sign;

      s3_sign        <= s2_sign;
      s3_exp         <= s2_exp;
      s3_sum         <= sum_next;
      s3_special     <= s2_special;
      s3_special_val <= s2_special_val;
      s3_zero_sign   <= s2_zero_sign;

      s4_sign        <= s3_sign;
      s4_exp         <= exp_norm_next;
      s4_norm        <= norm_next;
      s4_zero        <= zero_next;
      s4_zero_sign   <= zero_sign_next;
      s4_special     <= s3_special;
      s4_special_val <= s3_special_val;

      result_reg     <= result_next;
    end
  end

  assign result = result_reg;

  latency_timer #(
    .LATENCY     (ADD_LATENCY),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_latency_timer (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .done  (done)
  );

endmodule

// File: tb/tb_fp32_add_timed.sv
// Self-checking bench for fp32_add_timed: directed cases plus random operands
// checked against a double-precision reference rounded back to FP32.
module tb_fp32_add_timed;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa, datab;
  logic [31:0] result;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp32_add_timed dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model
  function automatic real fp_to_real(input logic [31:0] x);
    logic [63:0] b;
    if (x[30:23] == 8'h00) return 0.0;
    b = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'h0};
    return $bitstoreal(b);
  endfunction

  // Double holds any FP32 sum closely enough that one RNE step to FP32 is exact-rounded.
  function automatic logic [31:0] real_to_fp(input real d);
    logic [63:0] b;
    logic [53:0] m;
    logic [24:0] hi;
    logic [28:0] rem;
    int          e;
    if (d == 0.0) return 32'h0;
    b = $realtobits(d);
    e = int'(b[62:52]) - 1023;
    if (e < -126) return 32'h0;
    m   = {2'b01, b[51:0]};
    hi  = 25'(m >> 29);
    rem = m[28:0];
    if ((rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && hi[0])) hi = hi + 25'd1;
    if (hi[24]) begin
      hi = hi >> 1;
      e++;
    end
    if (e + 127 >= 255) return {b[63], 8'hFF, 23'h0};
    return {b[63], 8'(e + 127), hi[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf && (a[31] != b[31])) return 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    if ((a[30:23] == 8'h00) && (b[30:23] == 8'h00)) return {a[31] & b[31], 31'h0};
    return real_to_fp(fp_to_real(a) + fp_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    int          sel;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [31:0] specials [7];
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0001, 32'h7F7F_FFFF, 32'hFF7F_FFFF};
    sel = $urandom_range(0, 15);
    s   = 1'($urandom_range(0, 1));
    f   = 23'($urandom);
    case (sel)
      0:       return specials[$urandom_range(0, 6)];
      1:       e = 8'h00;
      2:       e = 8'($urandom_range(1, 3));
      3:       e = 8'($urandom_range(252, 254));
      default: e = 8'($urandom_range(110, 140));
    endcase
    return {s, e, f};
  endfunction

  function automatic logic [31:0] rand_partner(input logic [31:0] a);
    logic [31:0] b;
    b = rand_fp();
    case ($urandom_range(0, 7))
      0:       b = {~a[31], a[30:0]};
      1:       b = {~a[31], a[30:23], 23'($urandom)};
      default: ;
    endcase
    return b;
  endfunction

  // ---------------- scenarios
  task automatic run_single(input string name, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] expv);
    dataa  = a;
    datab  = b;
    start  = 1'b1;
    clk_en = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_early: done=%b expected 0 after edge 4", name, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || result !== expv) begin
      errors++;
      $display("FAIL %s edge5: result=%h done=%b expected result=%h done=1", name, result, done, expv);
    end
    step();
    checks++;
    if (done !== 1'b1 || result !== expv) begin
      errors++;
      $display("FAIL %s hold: result=%h done=%b expected result=%h done=1", name, result, done, expv);
    end
    $display("op %s: %h + %h -> %h (expected %h) done=%b", name, a, b, result, expv, done);
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = 32'h3F80_0000;
    datab  = 32'h3F80_0000;
    repeat (3) step();
    checks++;
    if (result !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: result=%h done=%b expected result=00000000 done=0", result, done);
    end
    rst = 1'b1;
    repeat (6) step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_done: done=%b expected 0 with no start", done);
    end
    $display("reset: result=%h done=%b", result, done);
  endtask

  task automatic test_directed();
    run_single("basic",         32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    run_single("cancel",        32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000);
    run_single("neg_zeros",     32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_single("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run_single("overflow",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    run_single("nan_in",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    run_single("tie_even",      32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    run_single("tie_up",        32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
    run_single("denorm_in",     32'h3F80_0000, 32'h0000_0001, 32'h3F80_0000);
    run_single("denorm_out",    32'h0080_0001, 32'h8080_0000, 32'h0000_0000);
    run_single("inf_finite",    32'hC000_0000, 32'hFF80_0000, 32'hFF80_0000);
  endtask

  task automatic test_random_single(input int n);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = rand_fp();
      b = rand_partner(a);
      run_single("rand", a, b, ref_add(a, b));
    end
  endtask

  task automatic test_back_to_back(input string name, input int n, input bit stall);
    logic [31:0] exp_q[$];
    logic [31:0] a, b, expv;
    logic        en;
    int          captured = 0;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      a  = rand_fp();
      b  = rand_partner(a);
      en = 1'b1;
      if (stall && ((i >= 8 && i <= 10) || ($urandom_range(0, 5) == 0))) en = 1'b0;
      dataa  = a;
      datab  = b;
      clk_en = en;
      step();
      if (en) begin
        exp_q.push_back(ref_add(a, b));
        captured++;
      end
      if (captured >= 5) begin
        expv = exp_q[captured-5];
        checks++;
        if (result !== expv) begin
          errors++;
          $display("FAIL %s cycle %0d: result=%h expected %h (clk_en=%b)", name, i, result, expv, en);
        end
        $display("%s cycle %0d: clk_en=%b result=%h expected %h", name, i, en, result, expv);
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    dataa  = 32'h4040_0000;
    datab  = 32'h3F80_0000;
    clk_en = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    checks++;
    if (result !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: result=%h done=%b expected result=00000000 done=0", result, done);
    end
    #1;
    rst = 1'b1;
    repeat (6) step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_done: done=%b expected 0 until a new start", done);
    end
    $display("reset_mid: result=%h done=%b", result, done);
  endtask

  task automatic test_restart();
    logic expd;
    dataa  = 32'h3F80_0000;
    datab  = 32'h4000_0000;
    clk_en = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      step();
      expd = (k == 7);
      checks++;
      if (done !== expd) begin
        errors++;
        $display("FAIL restart edge %0d: done=%b expected %b", k, done, expd);
      end
      $display("restart edge %0d: done=%b expected %b", k, done, expd);
    end
    checks++;
    if (result !== 32'h4040_0000) begin
      errors++;
      $display("FAIL restart_result: result=%h expected 40400000", result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_single(30);
    test_back_to_back("back_to_back", 40, 1'b0);
    test_back_to_back("stall", 40, 1'b1);
    test_reset_mid();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
